spi_slave: RTL and testbench

- SPI responder for the external-device end of the link driven by the team's SPI master control unit.
- Runs entirely in the system Clk domain.
  - Oversamples SCK, SS_n and MOSI through synchronisers.
  - Detects SCK edges according to CPol/CPha.
  - Shifts MOSI in and MISO out MSB-first, DATA_W bits per word.
  - Presents each received word with a one-cycle valid pulse.
- Supports back-to-back words while SS_n stays low.

---
 rtl/spi_slave.sv | 140 ++++++++++++++
 tb/tb_spi_slave.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave.sv
// SPI responder running in the Clk domain: SCK/SS_n/MOSI are oversampled,
// edges are decoded per CPol/CPha, and words shift MSB-first in both directions.
module spi_slave #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              CPol,
  input  logic              CPha,
  input  logic              SCK,
  input  logic              SS_n,
  input  logic              MOSI,
  output logic              MISO,
  output logic              MISO_En,
  input  logic [DATA_W-1:0] TxData,
  output logic              TxAck,
  output logic [DATA_W-1:0] RxData,
  output logic              RxValid,
  output logic              Busy
);
  localparam int CW = $clog2(DATA_W) + 1;

  typedef enum logic [3:0] {
    IDLE   = 4'b0001,
    LOAD   = 4'b0010,
    ACTIVE = 4'b0100,
    DONE   = 4'b1000
  } state_t;

  logic [SYNC_STAGES-1:0] sck_q, ss_q, mosi_q;
  logic                   s_sck, s_ss_n, s_mosi, s_sck_d;
  logic                   lead_edge, trail_edge, samp_edge, shft_edge, last_bit;
  state_t                 state;
  logic [CW-1:0]          cnt;
  logic [DATA_W-1:0]      tx_sh, rx_sh;
  logic                   skip;

  // SS_n stages preset high so reset never looks like a selected frame
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      sck_q   <= '0;
      ss_q    <= '1;
      mosi_q  <= '0;
      s_sck_d <= 1'b0;
    end else begin
      sck_q   <= {sck_q[SYNC_STAGES-2:0], SCK};
      ss_q    <= {ss_q[SYNC_STAGES-2:0], SS_n};
      mosi_q  <= {mosi_q[SYNC_STAGES-2:0], MOSI};
      s_sck_d <= s_sck;
    end
  end

  assign s_sck      = sck_q[SYNC_STAGES-1];
  assign s_ss_n     = ss_q[SYNC_STAGES-1];
  assign s_mosi     = mosi_q[SYNC_STAGES-1];
  assign lead_edge  = (s_sck_d == CPol) && (s_sck != CPol);
  assign trail_edge = (s_sck_d != CPol) && (s_sck == CPol);
  assign samp_edge  = CPha ? trail_edge : lead_edge;
  assign shft_edge  = CPha ? lead_edge : trail_edge;
  assign last_bit   = (cnt == CW'(DATA_W - 1));

  // tx_sh is cleared whenever the link is released, so MISO idles low
  assign MISO = tx_sh[DATA_W-1];

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      tx_sh   <= '0;
      rx_sh   <= '0;
      skip    <= 1'b0;
      MISO_En <= 1'b0;
      TxAck   <= 1'b0;
      RxData  <= '0;
      RxValid <= 1'b0;
      Busy    <= 1'b0;
    end else begin
      TxAck   <= 1'b0;
      RxValid <= 1'b0;
      case (state)
        IDLE: begin
          MISO_En <= 1'b0;
          Busy    <= 1'b0;
          cnt     <= '0;
          tx_sh   <= '0;
          if (!s_ss_n) state <= LOAD;
        end
        LOAD: begin
          if (s_ss_n) begin
            state <= IDLE;
          end else begin
            tx_sh   <= TxData;
            TxAck   <= 1'b1;
            cnt     <= '0;
            skip    <= CPha;
            MISO_En <= 1'b1;
            Busy    <= 1'b1;
            state   <= ACTIVE;
          end
        end
        ACTIVE: begin
          // a final sample edge wins over a simultaneous deselect
          if (samp_edge && (last_bit || !s_ss_n)) begin
            rx_sh <= {rx_sh[DATA_W-2:0], s_mosi};
            cnt   <= cnt + 1'b1;
            if (last_bit) state <= DONE;
          end else if (s_ss_n) begin
            state   <= IDLE;
            cnt     <= '0;
            tx_sh   <= '0;
            MISO_En <= 1'b0;
            Busy    <= 1'b0;
          end else if (shft_edge) begin
            if (skip) skip  <= 1'b0;
            else      tx_sh <= {tx_sh[DATA_W-2:0], 1'b0};
          end
        end
        DONE: begin
          RxData  <= rx_sh;
          RxValid <= 1'b1;
          cnt     <= '0;
          if (s_ss_n) begin
            state   <= IDLE;
            tx_sh   <= '0;
            MISO_En <= 1'b0;
            Busy    <= 1'b0;
          end else begin
            // new MSB goes out now; the next shift edge must not consume it
            tx_sh <= TxData;
            TxAck <= 1'b1;
            skip  <= 1'b1;
            state <= ACTIVE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: a bit-level SPI master plus word-level expectations
// (received words = words sent, MISO words = TxData values handed over at each TxAck).
`timescale 1ns/1ps
module tb_spi_slave;
  localparam int DATA_W      = 8;
  localparam int SYNC_STAGES = 2;
  localparam int HALF        = 8;

  logic              Clk   = 1'b0;
  logic              Rst_n = 1'b0;
  logic              CPol  = 1'b0;
  logic              CPha  = 1'b0;
  logic              SCK   = 1'b0;
  logic              SS_n  = 1'b1;
  logic              MOSI  = 1'b0;
  logic [DATA_W-1:0] TxData;
  logic              MISO, MISO_En, TxAck, RxValid, Busy;
  logic [DATA_W-1:0] RxData;

  int checks = 0, failures = 0;
  int n_ack = 0, n_rxv = 0;
  int ack_base = 0, rxv_base = 0;
  logic [DATA_W-1:0] tx_words   [16];
  logic [DATA_W-1:0] mosi_words [16];
  logic [DATA_W-1:0] miso_got   [16];
  logic [DATA_W-1:0] rx_log     [64];
  logic [DATA_W-1:0] model_rx = '0;
  logic              busy_mid, rst_pre_busy;
  logic [DATA_W+3:0] rst_snap;
  logic [1:0]        abort_snap;

  // word k of a frame is presented until the k-th TxAck of that frame
  assign TxData = tx_words[(n_ack - ack_base) & 15];

  spi_slave #(.DATA_W(DATA_W), .SYNC_STAGES(SYNC_STAGES)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .CPol(CPol), .CPha(CPha), .SCK(SCK), .SS_n(SS_n),
    .MOSI(MOSI), .MISO(MISO), .MISO_En(MISO_En), .TxData(TxData), .TxAck(TxAck),
    .RxData(RxData), .RxValid(RxValid), .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  always @(negedge Clk) begin
    if (RxValid === 1'b1) begin
      rx_log[n_rxv & 63] = RxData;
      n_rxv++;
    end
    if (TxAck === 1'b1) n_ack++;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: run did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge Clk);
    #2;
  endtask

  task automatic set_mode(input logic pol, input logic pha);
    CPol = pol;
    CPha = pha;
    SCK  = pol;
    wait_clk(4);
  endtask

  // stop_bits > 0 ends the frame after that many bits (reset pulse if do_rst)
  task automatic spi_xfer(input int nw, input int stop_bits, input bit do_rst);
    int nb;
    bit stop;
    nb = 0;
    stop = 1'b0;
    ack_base = n_ack;
    rxv_base = n_rxv;
    busy_mid = 1'b0;
    SS_n = 1'b0;
    wait_clk(HALF);
    for (int w = 0; w < nw && !stop; w++) begin
      logic [DATA_W-1:0] got;
      got = '0;
      for (int b = DATA_W-1; b >= 0 && !stop; b--) begin
        if (!CPha) begin
          MOSI = mosi_words[w][b];
          wait_clk(HALF);
          got[b] = MISO;
          if (nb == 0) busy_mid = Busy & MISO_En;
          SCK = ~CPol;
          wait_clk(HALF);
          SCK = CPol;
        end else begin
          SCK  = ~CPol;
          MOSI = mosi_words[w][b];
          wait_clk(HALF);
          got[b] = MISO;
          if (nb == 0) busy_mid = Busy & MISO_En;
          SCK = CPol;
          wait_clk(HALF);
        end
        nb++;
        if (nb == stop_bits) stop = 1'b1;
      end
      miso_got[w] = got;
    end
    if (stop && do_rst) begin
      rst_pre_busy = Busy;
      Rst_n = 1'b0;
      #1;
      rst_snap = {MISO, MISO_En, TxAck, RxValid, Busy, RxData} >> 1;
      rst_snap = {MISO, MISO_En, TxAck, Busy, RxData} | {3'b0, RxValid, {DATA_W{1'b0}}};
      SS_n = 1'b1;
      wait_clk(4);
      Rst_n = 1'b1;
      wait_clk(HALF);
    end else if (stop) begin
      SS_n = 1'b1;
      wait_clk(SYNC_STAGES + 1);
      abort_snap = {MISO_En, Busy};
      wait_clk(2 * HALF);
    end else begin
      wait_clk(HALF);
      SS_n = 1'b1;
      wait_clk(2 * HALF);
    end
  endtask

  task automatic test_reset;
    wait_clk(3);
    checks++;
    if ({MISO, MISO_En, TxAck, RxValid, Busy, RxData} !== '0) begin
      failures++;
      $display("FAIL reset_in_reset: outputs=%h expected 0", {MISO, MISO_En, TxAck, RxValid, Busy, RxData});
    end
    Rst_n = 1'b1;
    wait_clk(6);
    checks++;
    if ({MISO, MISO_En, TxAck, RxValid, Busy, RxData} !== '0) begin
      failures++;
      $display("FAIL reset_idle: outputs=%h expected 0", {MISO, MISO_En, TxAck, RxValid, Busy, RxData});
    end
  endtask

  task automatic test_single(input logic pol, input logic pha, input logic [DATA_W-1:0] tx,
                             input logic [DATA_W-1:0] rx);
    set_mode(pol, pha);
    tx_words[0]   = tx;
    tx_words[1]   = DATA_W'($urandom);
    mosi_words[0] = rx;
    spi_xfer(1, -1, 1'b0);
    checks++;
    if (miso_got[0] !== tx) begin
      failures++;
      $display("FAIL single_miso mode=%0d%0d: got=%h expected=%h", pol, pha, miso_got[0], tx);
    end
    checks++;
    if (RxData !== rx || rx_log[rxv_base & 63] !== rx) begin
      failures++;
      $display("FAIL single_rx mode=%0d%0d: got=%h expected=%h", pol, pha, RxData, rx);
    end
    checks++;
    if (n_rxv - rxv_base != 1 || n_ack - ack_base != 2) begin
      failures++;
      $display("FAIL single_pulses mode=%0d%0d: rxvalid=%0d txack=%0d expected 1 and 2",
               pol, pha, n_rxv - rxv_base, n_ack - ack_base);
    end
    checks++;
    if (busy_mid !== 1'b1) begin
      failures++;
      $display("FAIL single_busy mode=%0d%0d: busy&en=%b expected 1", pol, pha, busy_mid);
    end
    model_rx = rx;
  endtask

  task automatic test_back_to_back;
    for (int m = 1; m <= 2; m++) begin
      set_mode(m == 2, m == 1);
      tx_words[0]   = DATA_W'($urandom);
      tx_words[1]   = 8'h56;
      tx_words[2]   = DATA_W'($urandom);
      mosi_words[0] = 8'h12;
      mosi_words[1] = 8'h34;
      spi_xfer(2, -1, 1'b0);
      checks++;
      if (rx_log[rxv_base & 63] !== 8'h12 || rx_log[(rxv_base + 1) & 63] !== 8'h34) begin
        failures++;
        $display("FAIL b2b_rx mode=%0d: got=%h,%h expected 12,34", m,
                 rx_log[rxv_base & 63], rx_log[(rxv_base + 1) & 63]);
      end
      checks++;
      if (miso_got[0] !== tx_words[0] || miso_got[1] !== 8'h56) begin
        failures++;
        $display("FAIL b2b_miso mode=%0d: got=%h,%h expected %h,56", m, miso_got[0], miso_got[1], tx_words[0]);
      end
      checks++;
      if (n_rxv - rxv_base != 2 || n_ack - ack_base != 3) begin
        failures++;
        $display("FAIL b2b_pulses mode=%0d: rxvalid=%0d txack=%0d expected 2 and 3",
                 m, n_rxv - rxv_base, n_ack - ack_base);
      end
      model_rx = 8'h34;
    end
  endtask

  task automatic test_abort;
    set_mode(1'b0, 1'b0);
    tx_words[0]   = DATA_W'($urandom);
    mosi_words[0] = 8'hC3;
    spi_xfer(1, 5, 1'b0);
    checks++;
    if (abort_snap !== 2'b00) begin
      failures++;
      $display("FAIL abort_release: MISO_En,Busy=%b expected 00", abort_snap);
    end
    checks++;
    if (n_rxv - rxv_base != 0 || RxData !== model_rx) begin
      failures++;
      $display("FAIL abort_rx: rxvalid=%0d RxData=%h expected 0 and %h", n_rxv - rxv_base, RxData, model_rx);
    end
    checks++;
    if (n_ack - ack_base != 1) begin
      failures++;
      $display("FAIL abort_ack: txack=%0d expected 1", n_ack - ack_base);
    end
    tx_words[0]   = DATA_W'($urandom);
    mosi_words[0] = 8'h0F;
    spi_xfer(1, -1, 1'b0);
    checks++;
    if (RxData !== 8'h0F || miso_got[0] !== tx_words[0] || n_rxv - rxv_base != 1) begin
      failures++;
      $display("FAIL abort_next: rx=%h miso=%h expected 0f and %h", RxData, miso_got[0], tx_words[0]);
    end
    model_rx = 8'h0F;
  endtask

  task automatic test_reset_mid;
    set_mode(1'b0, 1'b0);
    tx_words[0]   = DATA_W'($urandom);
    mosi_words[0] = DATA_W'($urandom);
    spi_xfer(1, 3, 1'b1);
    checks++;
    if (rst_pre_busy !== 1'b1 || rst_snap !== '0) begin
      failures++;
      $display("FAIL reset_mid: busy_before=%b outputs=%h expected 1 and 0", rst_pre_busy, rst_snap);
    end
    model_rx = '0;
    tx_words[0]   = DATA_W'($urandom);
    mosi_words[0] = 8'h99;
    spi_xfer(1, -1, 1'b0);
    checks++;
    if (RxData !== 8'h99 || miso_got[0] !== tx_words[0]) begin
      failures++;
      $display("FAIL reset_after: rx=%h miso=%h expected 99 and %h", RxData, miso_got[0], tx_words[0]);
    end
    model_rx = 8'h99;
  endtask

  task automatic test_idle_sck;
    int a0, r0;
    logic bad;
    a0 = n_ack;
    r0 = n_rxv;
    bad = 1'b0;
    for (int i = 0; i < 24; i++) begin
      SCK  = ~SCK;
      MOSI = 1'($urandom);
      for (int k = 0; k < 3; k++) begin
        wait_clk(1);
        bad |= MISO_En | TxAck | RxValid | Busy;
      end
    end
    checks++;
    if (bad !== 1'b0 || n_ack != a0 || n_rxv != r0) begin
      failures++;
      $display("FAIL idle_sck: activity=%b txack=%0d rxvalid=%0d expected 0,0,0", bad, n_ack - a0, n_rxv - r0);
    end
    checks++;
    if (RxData !== model_rx) begin
      failures++;
      $display("FAIL idle_rxdata: got=%h expected=%h", RxData, model_rx);
    end
  endtask

  task automatic test_random;
    for (int it = 0; it < 8; it++) begin
      int nw, md;
      md = $urandom_range(0, 3);
      nw = $urandom_range(1, 3);
      set_mode(md[1], md[0]);
      for (int w = 0; w <= nw; w++) begin
        tx_words[w]   = DATA_W'($urandom);
        mosi_words[w] = DATA_W'($urandom);
      end
      spi_xfer(nw, -1, 1'b0);
      for (int w = 0; w < nw; w++) begin
        checks++;
        if (miso_got[w] !== tx_words[w] || rx_log[(rxv_base + w) & 63] !== mosi_words[w]) begin
          failures++;
          $display("FAIL rand_word it=%0d mode=%0d w=%0d: miso=%h rx=%h expected %h %h", it, md, w,
                   miso_got[w], rx_log[(rxv_base + w) & 63], tx_words[w], mosi_words[w]);
        end
      end
      checks++;
      if (n_rxv - rxv_base != nw || n_ack - ack_base != nw + 1 || RxData !== mosi_words[nw-1]) begin
        failures++;
        $display("FAIL rand_frame it=%0d: rxvalid=%0d txack=%0d rx=%h expected %0d %0d %h", it,
                 n_rxv - rxv_base, n_ack - ack_base, RxData, nw, nw + 1, mosi_words[nw-1]);
      end
      model_rx = mosi_words[nw-1];
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      tx_words[i]   = '0;
      mosi_words[i] = '0;
      miso_got[i]   = '0;
    end
    test_reset();
    test_single(1'b0, 1'b0, 8'hA5, 8'h3C);
    test_single(1'b1, 1'b1, 8'h81, 8'hFF);
    test_back_to_back();
    test_abort();
    test_reset_mid();
    test_idle_sck();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
